// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset sequencer: FSM state encoding and
// default parameter values used by clk_rst_sequencer and clk_div_ch.
package clk_rst_pkg;

  // Sequencer states; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_HALT    = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_DOM     = 4;
  localparam int DEF_DIV_W       = 4;
  localparam int DEF_RST_HOLD    = 3;
  localparam int DEF_STAGGER     = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_CYCLE_LIMIT = 90;

endpackage

// File: rtl/clk_div_ch.sv
// One derived-clock channel: toggles its output every (div_i+1) input clocks.
// While halted, a high output finishes its half-period, then parks low with
// the counter cleared, so the domain always sees a clean low when frozen.
module clk_div_ch
  import clk_rst_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] div_i,
  input  logic             halt_i,
  output logic             clk_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;

  // Next-state: count and toggle when running or still finishing a high phase;
  // otherwise hold low with the counter at zero.
  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (!halt_i || clk_q) begin
      // >= keeps the channel well behaved if div_i shrinks below the count
      if (cnt_q >= div_i) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
      clk_d = 1'b0;
    end
  end

  // Counter and output flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_o = clk_q;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer: holds all domain resets for RST_HOLD cycles, releases
// them one by one STAGGER cycles apart, then counts RUN cycles. halt_req
// freezes the derived clocks (each parks low). Optional automatic halt after
// CYCLE_LIMIT RUN cycles is enabled by defining CLK_RST_CYCLE_LIMIT_EN.
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int NUM_DOM     = DEF_NUM_DOM,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_DOM*DIV_W-1:0] div_sel,
  input  logic                     halt_req,
  output logic [NUM_DOM-1:0]       dom_clk,
  output logic [NUM_DOM-1:0]       dom_rst_n,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic                     done
);

  // One sequence counter serves both the HOLD wait and the RELEASE staircase.
  localparam int REL_LAST = (NUM_DOM - 1) * STAGGER;
  localparam int SEQ_MAX  = (RST_HOLD > REL_LAST) ? RST_HOLD : REL_LAST;
  localparam int SEQ_W    = $clog2(SEQ_MAX + 1) + 1;
  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(RST_HOLD - 1);
  localparam logic [SEQ_W-1:0] REL_END   = SEQ_W'(REL_LAST);
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(CYCLE_LIMIT - 1);
`ifdef CLK_RST_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  seq_state_e               state_q, state_d;
  logic [SEQ_W-1:0]         seq_q, seq_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic [NUM_DOM-1:0]       rst_n_q, rst_n_d;
  logic [NUM_DOM*DIV_W-1:0] div_q, div_eff;

  // Next-state and counter logic of the sequencing FSM.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      ST_HOLD: begin
        if (seq_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_RELEASE: begin
        if (seq_q == REL_END) begin
          state_d = ST_RUN;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (halt_req) state_d = ST_HALT;
        // Limit wins over a simultaneous halt_req so done is still recorded
        if (LIMIT_EN && (cnt_d == LIMIT_VAL)) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
        end
      end
      ST_HALT: begin
        if (!halt_req && !done_q) state_d = ST_RUN;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Domain resets are registered from the next state so they never glitch;
  // bit i rises i*STAGGER cycles into RELEASE and stays high afterwards.
  for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_rst
    assign rst_n_d[gi] = (state_d == ST_RUN) || (state_d == ST_HALT) ||
                         ((state_d == ST_RELEASE) && (seq_d >= SEQ_W'(gi * STAGGER)));
  end

  // Sequencer state registers; div_sel is captured only while in HOLD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HOLD;
      seq_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rst_n_q <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rst_n_q <= rst_n_d;
      if (state_q == ST_HOLD) div_q <= div_sel;
    end
  end

  // In HOLD the dividers follow the live select so the first periods are
  // already correct; afterwards they use the captured copy.
  assign div_eff = (state_q == ST_HOLD) ? div_sel : div_q;

  for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_div
    clk_div_ch #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk_i  (clock),
      .rst_ni (reset),
      .div_i  (div_eff[gi*DIV_W +: DIV_W]),
      .halt_i (state_q == ST_HALT),
      .clk_o  (dom_clk[gi])
    );
  end

  assign dom_rst_n = rst_n_q;
  assign state     = state_q;
  assign cycle_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer. The reference model works from elapsed time
// since reset release: phase thresholds, divided-clock values by integer
// division, and halt/resume bookkeeping.
module tb_clk_rst_sequencer;

  localparam int ND     = 4;
  localparam int DW     = 4;
  localparam int HOLD_N = 3;
  localparam int STAG   = 2;
  localparam int REL_N  = (ND - 1) * STAG + 1;
  localparam int LIMIT  = 90;
  localparam int MAXC   = 65535;
`ifdef CLK_RST_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              halt_req = 1'b0;
  logic [ND*DW-1:0]  div_sel = '0;
  logic [ND-1:0]     dom_clk;
  logic [ND-1:0]     dom_rst_n;
  logic [1:0]        state;
  logic [15:0]       cycle_cnt;
  logic              done;

  int checks = 0;
  int failures = 0;

  // model state
  int since, m_state, run_cnt, anchor, th;
  bit m_done;
  int d [ND];

  clk_rst_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .div_sel   (div_sel),
    .halt_req  (halt_req),
    .dom_clk   (dom_clk),
    .dom_rst_n (dom_rst_n),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .done      (done)
  );

  always #5 clock = ~clock;

  function automatic bit fclk(input int t, input int a, input int dd);
    return (((t - a) / (dd + 1)) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, since, got, exp);
    end
  endtask

  task automatic check_all();
    logic [ND-1:0] ec, er;
    for (int i = 0; i < ND; i++) begin
      er[i] = (since >= HOLD_N + i * STAG);
      if (m_state != 3)
        ec[i] = fclk(since, anchor, d[i]);
      else
        ec[i] = fclk(th, anchor, d[i]) && fclk(since, anchor, d[i]) &&
                (((since - anchor) / (d[i] + 1)) == ((th - anchor) / (d[i] + 1)));
    end
    chk("state", 32'(state), 32'(m_state));
    chk("dom_rst_n", 32'(dom_rst_n), 32'(er));
    chk("dom_clk", 32'(dom_clk), 32'(ec));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(run_cnt));
    chk("done", 32'(done), 32'(m_done));
    $display("t=%0d st=%0d rst_n=%b clk=%b cnt=%0d done=%0d halt_req=%0d",
             since, state, dom_rst_n, dom_clk, cycle_cnt, done, halt_req);
  endtask

  // Assert reset asynchronously, check cleared outputs, release mid-cycle.
  task automatic do_reset(input logic [15:0] ds);
    reset = 1'b0;
    halt_req = 1'b0;
    div_sel = ds;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_dom_clk", 32'(dom_clk), 32'd0);
    chk("rst_dom_rst_n", 32'(dom_rst_n), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    since = 0; m_state = 0; run_cnt = 0; m_done = 1'b0; anchor = 0; th = 0;
    for (int i = 0; i < ND; i++) d[i] = (int'(ds) >> (DW * i)) & ((1 << DW) - 1);
    check_all();
  endtask

  // Advance one clock, apply the specification rules to the model, compare.
  task automatic step();
    bit hr;
    hr = halt_req;
    @(posedge clock);
    #1;
    since++;
    if (m_state < 2) begin
      if (since >= HOLD_N + REL_N) m_state = 2;
      else if (since >= HOLD_N) m_state = 1;
    end else if (m_state == 2) begin
      if (run_cnt < MAXC) run_cnt++;
      if (LIMIT_EN && run_cnt == LIMIT - 1) begin
        m_done = 1'b1; m_state = 3; th = since;
      end else if (hr) begin
        m_state = 3; th = since;
      end
    end else begin
      if (!hr && !m_done) begin
        m_state = 2; anchor = since;
      end
    end
    check_all();
  endtask

  initial begin
    bit hr_on;
    int seg, k;

    // default dividers, plain reset sequence
    do_reset(16'h0000);
    repeat (20) step();

    // distinct dividers: periods 8,6,4,2
    do_reset(16'h3210);
    repeat (30) step();

    // halt while the slowest clock is high, then resume
    k = 0;
    while (!(dom_clk[3] === 1'b1 && state === 2'd2) && k < 20) begin
      step();
      k++;
    end
    chk("wait_clk3_high", {29'd0, dom_clk[3], state}, 32'b110);
    halt_req = 1'b1;
    repeat (14) step();
    halt_req = 1'b0;
    repeat (20) step();

    // reset pulse after bit 1 has been released
    do_reset(16'h3210);
    repeat (5) step();
    do_reset(16'h3210);
    repeat (20) step();

    // randomized dividers, halt windows, ignored div_sel changes
    for (int it = 0; it < 3; it++) begin
      do_reset(16'($urandom));
      hr_on = 1'b1;
      seg = 0;
      for (int n = 0; n < 200; n++) begin
        step();
        if (m_state < 2) begin
          halt_req = 1'($urandom % 2);
          hr_on = 1'b1;
          seg = 0;
        end else begin
          if (seg == 0) begin
            hr_on = !hr_on;
            halt_req = hr_on;
            seg = hr_on ? int'($urandom_range(45, 34)) : int'($urandom_range(30, 5));
          end
          seg--;
          if ($urandom % 10 == 0) div_sel = 16'($urandom);
        end
      end
    end

    // long uninterrupted run past the cycle limit
    do_reset(16'h0123);
    repeat (110) step();
`ifdef CLK_RST_CYCLE_LIMIT_EN
    chk("limit_done", 32'(done), 32'd1);
    chk("limit_state", 32'(state), 32'd3);
    chk("limit_cnt", 32'(cycle_cnt), 32'd89);
    for (int j = 0; j < 6; j++) begin
      halt_req = ~halt_req;
      repeat (3) step();
    end
    chk("limit_no_resume", 32'(state), 32'd3);
`else
    chk("nolimit_done", 32'(done), 32'd0);
    chk("nolimit_cnt", 32'(cycle_cnt), 32'd100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
